// File: rtl/register_bank_pkg.sv
// Shared CPU definitions: data width, register address type, special
// addresses and the ALU opcode set used by the datapath.
package cpu_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic [2:0] reg_addr_t;

    localparam reg_addr_t ADDR_IO   = 3'd6;
    localparam reg_addr_t ADDR_ZERO = 3'd7;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_PASS = 3'd5
    } alu_op_t;

endpackage

// File: rtl/register_bank_if.sv
// Operand/writeback bus between the pipeline and the register bank,
// including the external input/output valid/ready streams.
interface register_bank_if #(parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH) ();
    import cpu_pkg::*;

    logic                  execute;
    reg_addr_t             readAddrA;
    reg_addr_t             readAddrB;
    logic [DATA_WIDTH-1:0] operandA;
    logic [DATA_WIDTH-1:0] operandB;
    logic                  writeEnable;
    reg_addr_t             writeAddr;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  stall;
    logic [DATA_WIDTH-1:0] inputData;
    logic                  inputValid;
    logic                  inputReady;
    logic [DATA_WIDTH-1:0] outputData;
    logic                  outputValid;
    logic                  outputReady;

    modport master (
        output execute, readAddrA, readAddrB, writeEnable, writeAddr, writeData,
        output inputData, inputValid, outputReady,
        input  operandA, operandB, stall, inputReady, outputData, outputValid
    );

    modport slave (
        input  execute, readAddrA, readAddrB, writeEnable, writeAddr, writeData,
        input  inputData, inputValid, outputReady,
        output operandA, operandB, stall, inputReady, outputData, outputValid
    );

endinterface

// File: rtl/register_bank_holding_register.sv
// One-entry buffer with a full flag. A load always wins over a drain, so a
// simultaneous load+drain replaces the word and leaves the entry full.
module holding_register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] loadData,
    input  logic                  drain,
    output logic                  full_r,
    output logic [DATA_WIDTH-1:0] data_r
);

    // Full flag and stored word, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else if (load) begin
            full_r <= 1'b1;
            data_r <= loadData;
        end else if (drain) begin
            full_r <= 1'b0;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Register bank feeding the ALU operands, with a write-through bypass and
// address 6 mapped onto buffered input/output streams that stall on I/O.
module register_bank
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = 6
) (
    input  logic            clock,
    input  logic            resetN,
    register_bank_if.slave  bus
);

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic                  inFull_r;
    logic [DATA_WIDTH-1:0] inData_r;
    logic                  outFull_r;
    logic [DATA_WIDTH-1:0] outData_r;

    logic                  readsIo_s;
    logic                  writesIo_s;
    logic                  readStall_s;
    logic                  writeStall_s;
    logic                  stall_s;
    logic                  commit_s;
    logic                  regWrite_s;
    logic                  inLoad_s;
    logic                  inDrain_s;
    logic                  outLoad_s;
    logic                  outDrain_s;
    logic [DATA_WIDTH-1:0] operandA_s;
    logic [DATA_WIDTH-1:0] operandB_s;

    function automatic logic isGpr(input reg_addr_t addr);
        return (addr < reg_addr_t'(NUM_REGS));
    endfunction

    // A committing register write is forwarded so the ALU never sees a stale value.
    function automatic logic [DATA_WIDTH-1:0] readPort(input reg_addr_t addr);
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (addr == ADDR_IO) begin
            value = inData_r;
        end else if (isGpr(addr)) begin
            if (regWrite_s && (bus.writeAddr == addr)) begin
                value = bus.writeData;
            end else begin
                value = regs_r[addr];
            end
        end else begin
            value = '0;
        end
        return value;
    endfunction

    // Stall and commit qualification; I/O read and write stalls are independent.
    always_comb begin
        readsIo_s    = (bus.readAddrA == ADDR_IO) || (bus.readAddrB == ADDR_IO);
        writesIo_s   = bus.writeEnable && (bus.writeAddr == ADDR_IO);
        readStall_s  = bus.execute && readsIo_s && !inFull_r;
        writeStall_s = bus.execute && writesIo_s && outFull_r && !bus.outputReady;
        stall_s      = readStall_s || writeStall_s;
        commit_s     = bus.execute && !stall_s;
        regWrite_s   = commit_s && bus.writeEnable && isGpr(bus.writeAddr);
        inLoad_s     = bus.inputValid && resetN && !inFull_r;
        inDrain_s    = commit_s && readsIo_s;
        outLoad_s    = commit_s && writesIo_s;
        outDrain_s   = outFull_r && bus.outputReady;
    end

    // Combinational read ports to the ALU.
    always_comb begin
        operandA_s = readPort(bus.readAddrA);
        operandB_s = readPort(bus.readAddrB);
    end

    // General-register file with a single synchronous write port.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (regWrite_s && (bus.writeAddr == reg_addr_t'(i))) begin
                    regs_r[i] <= bus.writeData;
                end
            end
        end
    end

    holding_register #(.DATA_WIDTH(DATA_WIDTH)) inputBuffer (
        .clock    (clock),
        .resetN   (resetN),
        .load     (inLoad_s),
        .loadData (bus.inputData),
        .drain    (inDrain_s),
        .full_r   (inFull_r),
        .data_r   (inData_r)
    );

    holding_register #(.DATA_WIDTH(DATA_WIDTH)) outputBuffer (
        .clock    (clock),
        .resetN   (resetN),
        .load     (outLoad_s),
        .loadData (bus.writeData),
        .drain    (outDrain_s),
        .full_r   (outFull_r),
        .data_r   (outData_r)
    );

    assign bus.operandA    = operandA_s;
    assign bus.operandB    = operandB_s;
    assign bus.stall       = stall_s;
    assign bus.inputReady  = resetN && !inFull_r;
    assign bus.outputValid = outFull_r;
    assign bus.outputData  = outData_r;

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Operand/writeback stage wrapped around the 8-bit ALU.
- Holds the general-purpose registers and drives the ALU's operandA/operandB from two combinational read ports.
- Captures the ALU result through one synchronous write port.
- Maps address 6 onto a one-entry input buffer (read side) and a one-entry output buffer (write side), each with a valid/ready handshake. Stalls the instruction when an I/O access cannot complete.

Parameters:
- DATA_WIDTH, 8, width of registers, operands and I/O data.
- NUM_REGS, 6, number of general registers, at addresses 0..NUM_REGS-1. Must be ≤ 6.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- resetN  input  1  synchronous, active-low reset.
- execute  input  1  an instruction is present this cycle; qualifies I/O reads and writes.
- readAddrA  input  3  register address for operandA.
- readAddrB  input  3  register address for operandB.
- operandA  output  DATA_WIDTH  combinational read data A, to the ALU.
- operandB  output  DATA_WIDTH  combinational read data B, to the ALU.
- writeEnable  input  1  write request for this instruction.
- writeAddr  input  3  destination address.
- writeData  input  DATA_WIDTH  data to write (ALU result).
- stall  output  1  instruction cannot complete this cycle; upstream holds all inputs.
- inputData  input  DATA_WIDTH  external input word.
- inputValid  input  1  inputData is valid.
- inputReady  output  1  input buffer can accept a word.
- outputData  output  DATA_WIDTH  external output word.
- outputValid  output  1  outputData is valid.
- outputReady  input  1  consumer accepts outputData.

Behaviour:
- Address map:
  - 0..NUM_REGS-1: general registers.
  - 6: I/O. Reads return the input buffer; writes go to the output buffer.
  - 7, and any unused address from NUM_REGS to 5: reads return 0, writes are ignored.
- Reset (resetN=0 at a clock edge):
  - All registers cleared to 0; input and output buffers emptied.
  - Outputs after reset: operandA/B follow the 0 register contents, outputValid=0, outputData=0, inputReady=0 while resetN=0, stall=0.
  - Reset mid-handshake discards the buffered words without acknowledgement.
- Register reads: zero-latency, combinational.
- Write-through bypass: if a register write commits this cycle and writeAddr equals the read address (register range only), the operand shows writeData, not the stale register.
- Read stall: execute=1 and (readAddrA==6 or readAddrB==6) and input buffer empty.
- Write stall: execute=1, writeEnable=1, writeAddr==6, output buffer full and outputReady=0.
- stall is the OR of read stall and write stall.
- Commit = execute and not stall. With stall=1 nothing changes: no register write, no consume, no output load.
- Register write: a commit with writeEnable=1 writes writeData into the register at the rising edge.
- Input buffer:
  - inputReady = resetN and buffer empty.
  - inputValid and inputReady at an edge loads inputData and sets full.
  - A commit that reads address 6 empties the buffer at the edge. This happens once even if both ports read 6; both operands see the same word.
  - No same-cycle refill after consume: one bubble cycle is accepted.
- Output buffer:
  - outputValid = full.
  - outputValid and outputReady at an edge clears full.
  - A commit writing address 6 loads writeData and sets full. If that load coincides with a drain (full, outputReady=1), the new word replaces the old one and full stays 1.
  - outputData is held stable while outputValid=1 and outputReady=0.
- Writing address 6 while reading address 6 in the same instruction is legal: both stall conditions are evaluated independently.
- Widths: all data is DATA_WIDTH. No arithmetic in this block.

Decomposition:
- Package cpu_pkg:
  - DATA_WIDTH.
  - reg_addr_t (3-bit).
  - Constants ADDR_IO=3'd6 and ADDR_ZERO=3'd7.
  - The ALU opcode enum (shared with the ALU).
- Sub-module holding_register: a one-entry valid/ready buffer with load/drain and a full flag. Instantiated twice, once for input and once for output.

Test Plan:
1. Reset, then write r2=0x55, then read A=2, B=7 → operandA=0x55, operandB=0x00; stall=0.
2. Bypass: writeEnable=1, writeAddr=3, writeData=0xAA, readAddrA=3 in the same cycle → operandA=0xAA in that cycle; r3=0xAA afterwards.
3. Input empty: execute=1, readAddrA=6 → stall=1 and no register write. Then drive inputData=0x0F, inputValid=1 → inputReady drops the next cycle, stall=0, operandA=0x0F, buffer consumed once with readAddrB=6 also set.
4. Output backpressure: write 0x11 to address 6 with outputReady=0 → outputValid=1, outputData=0x11. A second write of 0x22 → stall=1 and data stays 0x11. Raise outputReady → 0x22 loads in the same edge as the drain; outputValid stays 1.
5. Writes to address 7 and reads of 7 → always 0. Register r0..r5 contents unchanged.
6. Assert resetN=0 while the output buffer is full and the input buffer is full → next cycle outputValid=0, inputReady=0, all registers 0. After release, inputReady=1.
